xbus_cfg_fetch: RTL and testbench
=================================

XBUS_CFG_FETCH -- requirements
Module: xbus_cfg_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: output buffer depth in 32-bit words, power of two, at least 2.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 64: cycles waited in WAIT_ACK before error.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle job request, sampled in IDLE or ERR only.
REQ-006 SHALL have port base_addr, input, 32: first word address, sampled with start.
REQ-007 SHALL have port word_cnt, input, 12: words to fetch, sampled with start.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE and ERR.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when a job completes.
REQ-010 SHALL have port err, output, 1: sticky ack-timeout flag.
REQ-011 SHALL have port xbm_select, output, 1: xbus request strobe.
REQ-012 SHALL have ports xbm_addr, output, 32 (word address) and xbm_data, output, 32 (tied to 0).
REQ-013 SHALL have ports xbm_rnw, output, 1 (constant 1) and xbm_be, output, 4 (constant 4'hF).
REQ-014 SHALL have ports xbm_ack, input, 1 (slave ack pulse) and xbm_rdata, input, 32 (slave read data).
REQ-015 SHALL have ports cfg_valid, output, 1 and cfg_data, output, 32: downstream stream, FIFO head.
REQ-016 SHALL have port cfg_ready, input, 1: downstream accept; a transfer occurs when cfg_valid and cfg_ready are both high.

Function
REQ-017 SHALL implement states IDLE, REQ, WAIT_ACK, DRAIN, DONE, ERR.
REQ-018 IDLE, start=1: latch base_addr and word_cnt, clear idx; go to DONE if word_cnt==0, else to REQ.
REQ-019 REQ: when FIFO count < FIFO_DEPTH, drive xbm_select=1 for exactly one cycle with xbm_addr=base+idx, then go to WAIT_ACK; otherwise stall in REQ with select=0.
REQ-020 No more than one transaction SHALL be outstanding; xbm_select SHALL never be high in two consecutive cycles.
REQ-021 WAIT_ACK, xbm_ack=1: push xbm_rdata into the FIFO, idx++; go to DRAIN if idx==word_cnt, else to REQ.
REQ-022 WAIT_ACK SHALL count cycles from entry; reaching ACK_TIMEOUT without ack goes to ERR.
REQ-023 DRAIN: go to DONE when the FIFO is empty.
REQ-024 DONE: done=1 for one cycle, then go to IDLE.
REQ-025 ERR: err=1, FIFO flushed, cfg_valid=0; start=1 clears err and begins a job as in REQ-018.
REQ-026 Address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFFFFFF+1 wraps to 0.
REQ-027 xbm_ack outside WAIT_ACK SHALL be ignored and push nothing.
REQ-028 start while busy SHALL be ignored.
REQ-029 FIFO push and pop in the same cycle SHALL keep count unchanged; overflow cannot occur (REQ-019); pop when empty has no effect.
REQ-030 Latency: start at edge N gives xbm_select high in cycle N+1 (FIFO not full).
REQ-031 cfg_data SHALL preserve fetch order.

Reset
REQ-032 rst SHALL force state IDLE and clear FIFO, idx and timeout counter.
REQ-033 rst SHALL force outputs busy, done, err, xbm_select, cfg_valid to 0 and xbm_addr, cfg_data to 0.
REQ-034 rst mid-job SHALL abort without any further request; a late ack is discarded per REQ-027.

Structure
REQ-035 Package cfg_fetch_pkg SHALL hold the state enum, XBUS_BE_ALL=4'hF and the default parameter values.
REQ-036 Sub-module cfg_fifo SHALL be a synchronous FIFO (width 32, depth FIFO_DEPTH) with push, pop, full, empty and count outputs.

Verification
REQ-037 base=0x10, cnt=3, cfg_ready=1, memory words 0xA,0xB,0xC -> addresses 0x10,0x11,0x12 issued in order; cfg_data 0xA,0xB,0xC; one done pulse.
REQ-038 cnt=0 -> no xbm_select; done pulse two cycles after start.
REQ-039 cnt=8, FIFO_DEPTH=4, cfg_ready=0 -> exactly 4 requests, then stall in REQ; after cfg_ready=1, all 8 words delivered in order.
REQ-040 Slave never acks -> err rises ACK_TIMEOUT cycles after select and busy=0; next start clears err.
REQ-041 base=0xFFFFFFFE, cnt=3 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-042 rst during WAIT_ACK, ack arrives 2 cycles later -> cfg_valid stays 0; no done; state IDLE.

Source files
------------

// File: rtl/cfg_fetch_pkg.sv
// Shared types and defaults for the xbus configuration fetch engine.
package cfg_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [3:0] XBUS_BE_ALL         = 4'hF;
  localparam int         FIFO_DEPTH_DEFAULT  = 4;
  localparam int         ACK_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/xbus_cfg_fetch_if.sv
// Single-outstanding xbus read channel between the fetch engine and a slave.
interface xbus_cfg_fetch_if;

  logic        xbm_select;
  logic [31:0] xbm_addr;
  logic [31:0] xbm_data;
  logic        xbm_rnw;
  logic [3:0]  xbm_be;
  logic        xbm_ack;
  logic [31:0] xbm_rdata;

  modport master (
    output xbm_select, xbm_addr, xbm_data, xbm_rnw, xbm_be,
    input  xbm_ack, xbm_rdata
  );

  modport slave (
    input  xbm_select, xbm_addr, xbm_data, xbm_rnw, xbm_be,
    output xbm_ack, xbm_rdata
  );

endinterface

// File: rtl/cfg_fifo.sv
// 32-bit synchronous FIFO with flush; head word is visible on rdata while not empty.
module cfg_fifo
  import cfg_fetch_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   wdata,
  input  logic          pop,
  output logic [31:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/xbus_cfg_fetch.sv
// Fetches word_cnt consecutive words over xbus, one request at a time, and
// streams them downstream through a small FIFO that back-pressures requests.
module xbus_cfg_fetch
  import cfg_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [11:0]        word_cnt,
  output logic               busy,
  output logic               done,
  output logic               err,
  xbus_cfg_fetch_if.master   xbm,
  output logic               cfg_valid,
  output logic [31:0]        cfg_data,
  input  logic               cfg_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [11:0]   idx_q, idx_d;
  logic [11:0]   idx_inc;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          done_q, done_d;
  logic          sel;
  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_head;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    sel       = 1'b0;
    fifo_push = 1'b0;
    idx_inc   = idx_q + 12'd1;
    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          base_d  = base_addr;
          cnt_d   = word_cnt;
          idx_d   = '0;
          state_d = (word_cnt == 12'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (fifo_count < CW'(FIFO_DEPTH)) begin
          sel     = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (xbm.xbm_ack) begin
          fifo_push = !fifo_full;
          idx_d     = idx_inc;
          state_d   = (idx_inc == cnt_q) ? S_DRAIN : S_REQ;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DRAIN:  if (fifo_empty) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // done is registered, so the pulse trails the DONE state by one cycle.
    done_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
    cnt_q  <= cnt_d;
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_ERR);
  assign err  = (state_q == S_ERR);
  assign done = done_q;

  // Request is masked during reset so an aborted job never issues another read.
  assign xbm.xbm_select = sel && !rst;
  assign xbm.xbm_addr   = xbm.xbm_select ? (base_q + {20'd0, idx_q}) : 32'd0;
  assign xbm.xbm_data   = 32'd0;
  assign xbm.xbm_rnw    = 1'b1;
  assign xbm.xbm_be     = XBUS_BE_ALL;

  assign fifo_flush = (state_q == S_ERR);
  assign cfg_valid  = !fifo_empty && (state_q != S_ERR);
  assign cfg_data   = cfg_valid ? fifo_head : 32'd0;
  assign fifo_pop   = cfg_valid && cfg_ready;

  cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (xbm.xbm_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_xbus_cfg_fetch.sv
// Directed and randomized checks of xbus_cfg_fetch against an address/data model.
module tb_xbus_cfg_fetch;

  localparam int FD = 4;
  localparam int AT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [11:0] word_cnt = 12'd0;
  logic        busy, done, err, cfg_valid;
  logic [31:0] cfg_data;
  logic        cfg_ready = 1'b0;

  xbus_cfg_fetch_if xbm ();

  xbus_cfg_fetch #(.FIFO_DEPTH(FD), .ACK_TIMEOUT(AT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .xbm       (xbm),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
  int          sel_cnt = 0;
  int          n_done = 0;
  int          done_base = 0;
  int          consec_sel = 0;
  bit          prev_sel = 1'b0;
  int          slave_dly = -1;
  bit          slave_mute = 1'b0;
  int          ready_mode = 1;

  // Slave: records each request, answers after 1+dly cycles unless muted.
  initial begin : slave
    logic [31:0] a;
    int d;
    xbm.xbm_ack   = 1'b0;
    xbm.xbm_rdata = 32'd0;
    @(negedge clk);
    forever begin
      if (xbm.xbm_select === 1'b1) begin
        a = xbm.xbm_addr;
        got_addr.push_back(a);
        sel_cnt++;
        if (!slave_mute) begin
          d = (slave_dly < 0) ? int'($urandom_range(0, 3)) : slave_dly;
          repeat (d + 1) @(negedge clk);
          xbm.xbm_ack   = 1'b1;
          xbm.xbm_rdata = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
          @(negedge clk);
          xbm.xbm_ack   = 1'b0;
          xbm.xbm_rdata = 32'd0;
        end else begin
          @(negedge clk);
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       cfg_ready = 1'b0;
      1:       cfg_ready = 1'b1;
      default: cfg_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (xbm.xbm_select === 1'b1 && prev_sel) consec_sel++;
    prev_sel = (xbm.xbm_select === 1'b1);
    if (cfg_valid === 1'b1 && cfg_ready === 1'b1) got_data.push_back(cfg_data);
    if (done === 1'b1) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a job fetches base+i (mod 2^32) for i < cnt and delivers mem[] in that order.
  task automatic start_job(input logic [31:0] b, input logic [11:0] c, input bit keep);
    logic [31:0] a;
    exp_addr.delete();
    exp_data.delete();
    got_addr.delete();
    got_data.delete();
    sel_cnt   = 0;
    done_base = n_done;
    for (int i = 0; i < int'(c); i++) begin
      a = b + 32'(i);
      if (!keep || !mem.exists(a)) mem[a] = $urandom;
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
    end
    start     = 1'b1;
    base_addr = b;
    word_cnt  = c;
    @(negedge clk);
    start     = 1'b0;
    base_addr = $urandom;
    word_cnt  = 12'($urandom);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (n_done == done_base && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(n_done != done_base), 32'd1);
    cyc(2);
    chk({tag, "_one_done"}, 32'(n_done - done_base), 32'd1);
  endtask

  task automatic check_job(input string tag);
    chk({tag, "_n_addr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++)
      if (i < got_addr.size()) chk({tag, "_addr"}, got_addr[i], exp_addr[i]);
    chk({tag, "_n_data"}, 32'(got_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size(); i++)
      if (i < got_data.size()) chk({tag, "_data"}, got_data[i], exp_data[i]);
  endtask

  initial begin
    logic [31:0] rb;
    int          rc;

    rst = 1'b1;
    cyc(3);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_err",    32'(err), 32'd0);
    chk("rst_select", 32'(xbm.xbm_select), 32'd0);
    chk("rst_valid",  32'(cfg_valid), 32'd0);
    chk("rst_addr",   xbm.xbm_addr, 32'd0);
    chk("rst_data",   cfg_data, 32'd0);
    rst = 1'b0;
    cyc(1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("const_rnw", 32'(xbm.xbm_rnw), 32'd1);
    chk("const_be",  32'(xbm.xbm_be), 32'hF);

    // Basic three-word job with known memory contents.
    ready_mode = 1;
    mem[32'h10] = 32'hA;
    mem[32'h11] = 32'hB;
    mem[32'h12] = 32'hC;
    start_job(32'h10, 12'd3, 1'b1);
    chk("lat_select", 32'(xbm.xbm_select), 32'd1);
    chk("lat_addr",   xbm.xbm_addr, 32'h10);
    chk("lat_busy",   32'(busy), 32'd1);
    wait_done("basic", 100);
    check_job("basic");

    // Zero-length job: no request, done two cycles after start.
    start_job(32'h40, 12'd0, 1'b0);
    chk("zero_sel",       32'(xbm.xbm_select), 32'd0);
    chk("zero_busy",      32'(busy), 32'd1);
    chk("zero_done_early", 32'(done), 32'd0);
    cyc(1);
    chk("zero_done",      32'(done), 32'd1);
    chk("zero_busy_end",  32'(busy), 32'd0);
    cyc(3);
    chk("zero_no_req",    32'(sel_cnt), 32'd0);
    chk("zero_one_done",  32'(n_done - done_base), 32'd1);

    // Back-pressure: FIFO fills, requests stall until the consumer drains it.
    ready_mode = 0;
    start_job(32'h1000, 12'd8, 1'b0);
    cyc(40);
    chk("stall_req_cnt", 32'(sel_cnt), 32'd4);
    chk("stall_busy",    32'(busy), 32'd1);
    chk("stall_valid",   32'(cfg_valid), 32'd1);
    chk("stall_head",    cfg_data, exp_data[0]);
    chk("stall_no_sel",  32'(xbm.xbm_select), 32'd0);
    start     = 1'b1;
    base_addr = 32'h999;
    word_cnt  = 12'd1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    chk("busy_start_ignored", 32'(sel_cnt), 32'd4);
    ready_mode = 1;
    wait_done("fill", 200);
    check_job("fill");

    // Address wrap at the top of the 32-bit space.
    start_job(32'hFFFF_FFFE, 12'd3, 1'b0);
    wait_done("wrap", 100);
    check_job("wrap");

    // Random jobs with random ack latency and random consumer stalls.
    ready_mode = 2;
    for (int j = 0; j < 6; j++) begin
      rb = $urandom;
      rc = int'($urandom_range(1, 10));
      start_job(rb, 12'(rc), 1'b0);
      wait_done("rand", 400);
      check_job("rand");
    end

    // Ack timeout: err after AT cycles in WAIT_ACK, sticky until the next start.
    ready_mode = 1;
    slave_mute = 1'b1;
    start_job(32'h2000, 12'd2, 1'b0);
    chk("tmo_sel", 32'(xbm.xbm_select), 32'd1);
    cyc(AT);
    chk("tmo_err_early", 32'(err), 32'd0);
    cyc(1);
    chk("tmo_err",    32'(err), 32'd1);
    chk("tmo_busy",   32'(busy), 32'd0);
    chk("tmo_valid",  32'(cfg_valid), 32'd0);
    cyc(5);
    chk("tmo_sticky", 32'(err), 32'd1);
    chk("tmo_one_req", 32'(sel_cnt), 32'd1);
    slave_mute = 1'b0;
    start_job(32'h3000, 12'd2, 1'b0);
    chk("err_cleared", 32'(err), 32'd0);
    chk("err_restart_busy", 32'(busy), 32'd1);
    wait_done("after_err", 100);
    check_job("after_err");

    // Reset while waiting for ack; the ack then lands two cycles later.
    slave_dly = 2;
    start_job(32'h4000, 12'd2, 1'b0);
    chk("rst_job_sel", 32'(xbm.xbm_select), 32'd1);
    cyc(1);
    chk("rst_job_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("late_ack_valid", 32'(cfg_valid), 32'd0);
      cyc(1);
    end
    chk("late_ack_busy",    32'(busy), 32'd0);
    chk("late_ack_err",     32'(err), 32'd0);
    chk("late_ack_no_done", 32'(n_done - done_base), 32'd0);
    chk("late_ack_no_req",  32'(sel_cnt), 32'd1);
    chk("late_ack_no_data", 32'(got_data.size()), 32'd0);
    slave_dly = -1;
    start_job(32'h5000, 12'd3, 1'b0);
    wait_done("recover", 100);
    check_job("recover");

    chk("no_b2b_select", 32'(consec_sel), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
